wb_scoreboard: RTL

- Tracks destination registers with writes in flight between issue and the MEM3/WB register-file write port.
- Stalls issue of any instruction whose source operands still have a pending writeback.
- Sits beside the integer register array. Decode/issue drives it on one side; the MEM3/WB writeback bus (valid + rd index) retires entries on the other.
- Register x0 is never tracked.

---
 rtl/wb_scoreboard.sv | 73 +++++++
 1 files changed

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register in-flight write counters that stall issue on RAW hazards and full counters.
// Optional SB_WB_BYPASS_EN adds RS1_FWD/RS2_FWD for same-cycle writeback forwarding.
module wb_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ISSUE_VALID,
    input  logic [4:0]  ISSUE_RS1,
    input  logic [4:0]  ISSUE_RS2,
    input  logic        RS1_USED,
    input  logic        RS2_USED,
    input  logic        ISSUE_RD_VALID,
    input  logic [4:0]  ISSUE_RD,
    input  logic        FLUSH,
    input  logic        RD_WB_VALID_MEM3_WB,
    input  logic [4:0]  RD_WB_MEM3_WB,
    output logic        STALL,
    output logic        RS1_PENDING,
    output logic        RS2_PENDING,
    output logic [31:0] PEND_VEC,
`ifdef SB_WB_BYPASS_EN
    output logic        RS1_FWD,
    output logic        RS2_FWD,
`endif
    output logic        SB_ERR
);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic [31:1][CNT_W-1:0] cnt;
    logic [31:0][CNT_W-1:0] cv, cnt_d;
    logic [31:0] pend_d;
    logic rs1_hit, rs2_hit, rd_full, inc, dec, err, fwd1, fwd2, wb_nz;
    // x0 reads as a permanently empty counter
    assign cv = {cnt, {CNT_W{1'b0}}};
    assign wb_nz = RD_WB_VALID_MEM3_WB & (|RD_WB_MEM3_WB);
    assign rs1_hit = ISSUE_VALID & RS1_USED & (|ISSUE_RS1) & (|cv[ISSUE_RS1]);
    assign rs2_hit = ISSUE_VALID & RS2_USED & (|ISSUE_RS2) & (|cv[ISSUE_RS2]);
`ifdef SB_WB_BYPASS_EN
    assign fwd1 = rs1_hit & wb_nz & (RD_WB_MEM3_WB == ISSUE_RS1) & (cv[ISSUE_RS1] == CNT_W'(1)) & ~FLUSH;
    assign fwd2 = rs2_hit & wb_nz & (RD_WB_MEM3_WB == ISSUE_RS2) & (cv[ISSUE_RS2] == CNT_W'(1)) & ~FLUSH;
    assign RS1_FWD = fwd1;
    assign RS2_FWD = fwd2;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif
    assign RS1_PENDING = rs1_hit & ~fwd1;
    assign RS2_PENDING = rs2_hit & ~fwd2;
    assign rd_full = ISSUE_VALID & ISSUE_RD_VALID & (|ISSUE_RD) & (cv[ISSUE_RD] == MAX);
    assign STALL = RS1_PENDING | RS2_PENDING | rd_full | FLUSH;
    assign inc = ISSUE_VALID & ~STALL & ISSUE_RD_VALID & (|ISSUE_RD);
    assign dec = wb_nz & (|cv[RD_WB_MEM3_WB]);
    assign err = wb_nz & ~(|cv[RD_WB_MEM3_WB]) & ~FLUSH;
    always_comb begin
        cnt_d = '0;
        pend_d = '0;
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = FLUSH ? '0 : cv[i] + CNT_W'(inc && ISSUE_RD == 5'(i)) - CNT_W'(dec && RD_WB_MEM3_WB == 5'(i));
            pend_d[i] = |cnt_d[i];
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            PEND_VEC <= '0;
            SB_ERR <= 1'b0;
        end else begin
            cnt <= cnt_d[31:1];
            PEND_VEC <= pend_d;
            SB_ERR <= SB_ERR | err;
        end
    end
endmodule
